// File: rtl/bp_io_scratch_responder.sv
// IO command terminal: serves bp_cce_mem_msg_s commands from a local dword scratchpad (BP_IO_SCRATCH_RANGE_CHECK_EN adds range checking).
// Latency: accept in N, response valid in N+1; one command per 2 cycles; the response is held while io_resp_ready_i is low.
package bp_io_scratch_pkg;

  typedef enum int {e_bp_inv_cfg = 0} bp_params_e;

  localparam int paddr_width_p     = 40;
  localparam int cce_block_width_p = 512;
  localparam int lce_id_width_p    = 4;
  localparam int lce_assoc_p       = 8;

  typedef enum logic [3:0] {
    e_cce_mem_rd    = 4'b0000,
    e_cce_mem_wr    = 4'b0001,
    e_cce_mem_uc_rd = 4'b0010,
    e_cce_mem_uc_wr = 4'b0011,
    e_cce_mem_pre   = 4'b0100
  } bp_cce_mem_cmd_type_e;

  typedef struct packed {
    logic [lce_id_width_p-1:0]       lce_id;
    logic [$clog2(lce_assoc_p)-1:0]  way_id;
  } bp_cce_mem_payload_s;

  typedef struct packed {
    bp_cce_mem_payload_s     payload;
    logic [2:0]              size;
    logic [paddr_width_p-1:0] addr;
    bp_cce_mem_cmd_type_e    msg_type;
  } bp_cce_mem_msg_hdr_s;

  typedef struct packed {
    bp_cce_mem_msg_hdr_s          header;
    logic [cce_block_width_p-1:0] data;
  } bp_cce_mem_msg_s;

  function automatic int cce_mem_msg_width(bp_params_e cfg);
    return (cfg == e_bp_inv_cfg) ? $bits(bp_cce_mem_msg_s) : $bits(bp_cce_mem_msg_s);
  endfunction

endpackage

module bp_io_scratch_responder
  import bp_io_scratch_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_inv_cfg,
  parameter int els_p = 64,
  localparam int cce_mem_msg_width_lp = cce_mem_msg_width(bp_params_p)
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [cce_mem_msg_width_lp-1:0] io_cmd_i,
  input  logic                            io_cmd_v_i,
  output logic                            io_cmd_yumi_o,
  output logic [cce_mem_msg_width_lp-1:0] io_resp_o,
  output logic                            io_resp_v_o,
  input  logic                            io_resp_ready_i
);

  localparam int lg_els_lp = $clog2(els_p);

  typedef enum logic {e_ready, e_resp} state_e;

  state_e state_q, state_n;
  bp_cce_mem_msg_s cmd, resp;
  bp_cce_mem_msg_hdr_s hdr_q;

  logic [63:0] mem [els_p];
  logic [63:0] rd_q, shifted, rep, resp_data;
  logic [2:0] off, nm, off_q, nm_q;
  logic [lg_els_lp-1:0] idx;
  logic [7:0] mask;
  logic accept, is_rd, is_wr, oor, wr_en;
  logic is_rd_q, oor_q;
  logic unused_data;

  assign cmd = bp_cce_mem_msg_s'(io_cmd_i);
  assign unused_data = ^cmd.data[cce_block_width_p-1:64];

  always_comb begin
    off   = cmd.header.addr[2:0];
    idx   = cmd.header.addr[3 +: lg_els_lp];
    // nm = byte count - 1; sizes above a dword clamp to 8 bytes
    nm    = (cmd.header.size >= 3'd3) ? 3'd7 : 3'((4'd1 << cmd.header.size) - 4'd1);
    is_rd = cmd.header.msg_type inside {e_cce_mem_rd, e_cce_mem_uc_rd};
    is_wr = cmd.header.msg_type inside {e_cce_mem_wr, e_cce_mem_uc_wr};
`ifdef BP_IO_SCRATCH_RANGE_CHECK_EN
    oor   = |(cmd.header.addr >> (3 + lg_els_lp));
`else
    oor   = 1'b0;
`endif
    mask = '0;
    for (int b = 0; b < 8; b++) begin
      mask[b] = (4'(b) >= {1'b0, off}) && ((4'(b) - {1'b0, off}) <= {1'b0, nm});
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= e_ready;
    else         state_q <= state_n;
  end

  always_comb begin
    state_n       = state_q;
    io_cmd_yumi_o = 1'b0;
    io_resp_v_o   = 1'b0;
    case (state_q)
      e_ready: begin
        io_cmd_yumi_o = io_cmd_v_i & ~reset_i;
        if (io_cmd_v_i) state_n = e_resp;
      end
      e_resp: begin
        io_resp_v_o = 1'b1;
        if (io_resp_ready_i) state_n = e_ready;
      end
      default: state_n = e_ready;
    endcase
  end

  assign accept = io_cmd_yumi_o;
  assign wr_en  = accept & is_wr & ~oor & ~reset_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hdr_q   <= '0;
      rd_q    <= '0;
      off_q   <= '0;
      nm_q    <= '0;
      is_rd_q <= 1'b0;
      oor_q   <= 1'b0;
    end else if (accept) begin
      hdr_q   <= cmd.header;
      rd_q    <= mem[idx];
      off_q   <= off;
      nm_q    <= nm;
      is_rd_q <= is_rd;
      oor_q   <= oor;
    end
  end

  // Scratchpad array is intentionally left unreset
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 8; b++) begin
      if (wr_en && mask[b]) mem[idx][8*b +: 8] <= cmd.data[8*b +: 8];
    end
  end

  always_comb begin
    shifted = rd_q >> {off_q, 3'b000};
    rep     = '0;
    for (int j = 0; j < 8; j++) begin
      rep[8*j +: 8] = shifted[{3'(j) & nm_q, 3'b000} +: 8];
    end
    resp_data   = is_rd_q ? (oor_q ? '1 : rep) : '0;
    resp.header = hdr_q;
    resp.data   = cce_block_width_p'(resp_data);
  end

  assign io_resp_o = resp;

endmodule

// File: doc/bp_io_scratch_responder.md
# bp_io_scratch_responder

Terminal responder at the far end of the IO command/response path: accepts `bp_cce_mem_msg_s` IO commands, as delivered by the IO link's receive side, and serves them from a small local dword scratchpad. It returns one response per command. This is the device-side counterpart to the IO tile's command initiator. It sits behind `bp_me_cce_to_mem_link_bidir` on a device tile and gives the IO NoC a self-contained, testable target.

## Interface
- `bp_params_p`, default `e_bp_inv_cfg`: processor parameter set; supplies `paddr_width_p`, `cce_block_width_p`, `lce_id_width_p`, `lce_assoc_p`.
- `els_p`, default 64: scratchpad depth in 64-bit dwords; must be a power of 2, at least 2.
- `clk_i`, in, 1: the only clock.
- `reset_i`, in, 1: asynchronous, active-high reset.
- `io_cmd_i`, in, `cce_mem_msg_width_lp`: incoming command message.
- `io_cmd_v_i`, in, 1: command valid.
- `io_cmd_yumi_o`, out, 1: command consumed this cycle.
- `io_resp_o`, out, `cce_mem_msg_width_lp`: response message.
- `io_resp_v_o`, out, 1: response valid.
- `io_resp_ready_i`, in, 1: downstream ready; a transfer occurs when `io_resp_v_o & io_resp_ready_i`.

## Operation
- FSM states:
  - `e_ready`: idle, may accept a command.
  - `e_resp`: response pending.
- Transitions:
  - `e_ready` to `e_resp` when `io_cmd_v_i`. In that cycle `io_cmd_yumi_o = 1` and the command header is latched.
  - `e_resp` to `e_ready` when `io_resp_ready_i`.
- `io_cmd_yumi_o = (state == e_ready) & io_cmd_v_i`. It never depends on `io_resp_ready_i`.
- Address decode:
  - Byte offset `off = addr[2:0]`.
  - Dword index `idx = addr[3 +: lg(els_p)]`.
  - Byte count `n = 2^size`, clamped to 8 for sizes above 8 bytes.
  - Byte mask is `n` ones starting at `off`. Misaligned accesses are not checked; bytes beyond lane 7 are dropped.
- Read commands (`e_cce_mem_uc_rd`, `e_cce_mem_rd`):
  - A synchronous scratchpad read is issued in the accept cycle.
  - Response data is the selected `n` bytes, shifted to the LSB and replicated to fill 64 bits, then zero-extended to `cce_block_width_p`.
- Write commands (`e_cce_mem_uc_wr`, `e_cce_mem_wr`):
  - The masked bytes of `io_cmd_i.data[63:0]` are written at `idx` on the accept cycle.
  - Response data is zero.
- Any other `msg_type`: no scratchpad effect; response data is zero.
- Response header is the latched command header, unmodified: `msg_type`, `addr`, `size`, `payload`.
- The response is held stable while `io_resp_v_o & ~io_resp_ready_i`.

## Timing
- Reset values: state `e_ready`; `io_resp_v_o = 0`; `io_cmd_yumi_o = 0` (while `io_cmd_v_i` is low); `io_resp_o = 0`.
- Scratchpad contents are not reset and are undefined until written.
- Latency: command accepted in cycle N; `io_resp_v_o` is high in cycle N+1 for every command type.
- Throughput: at most one command per 2 cycles. No new command is accepted in the cycle the response handshakes; acceptance resumes the following cycle.
- Read-after-write: a write accepted in cycle N is visible to a read accepted in cycle N+2 or later. The FSM spacing guarantees this.
- Reset asserted mid-operation: the FSM returns to `e_ready` and any pending response is discarded immediately. A scratchpad write completes only if its accept edge precedes reset.
- Backpressure: with `io_resp_ready_i` held low indefinitely, `io_resp_v_o` stays high, `io_cmd_yumi_o` stays 0, and no commands are lost.

## Configuration
- `BP_IO_SCRATCH_RANGE_CHECK_EN` defined:
  - Addresses with any bit at or above `3 + lg(els_p)` set are out of range.
  - Out-of-range writes are dropped.
  - Out-of-range reads return all ones (`64'hFFFF_FFFF_FFFF_FFFF`, zero-extended).
  - A response is still returned with unchanged latency.
- Not defined: upper address bits are ignored and the index wraps modulo `els_p`.

## Test plan
- Reset, then an 8-byte `uc_wr` of `64'h0123_4567_89AB_CDEF` to addr `0x10`, then an 8-byte `uc_rd` of `0x10` -> write response data 0; read response at accept+1 returns data `64'h0123_4567_89AB_CDEF`, header echoed with the same `payload`.
- 1-byte `uc_wr` of `8'h5A` to `0x13` over the prior dword, then a 1-byte read of `0x13` -> data `64'h5A5A_5A5A_5A5A_5A5A`. An 8-byte read of `0x10` -> `64'h0123_4567_5A AB_CDEF` with only byte 3 replaced, i.e. `64'h0123_4567_5AAB_CDEF`.
- Hold `io_resp_ready_i = 0` for 10 cycles with `io_cmd_v_i` high -> response held stable, `io_cmd_yumi_o = 0` throughout; release -> handshake, next accept one cycle later.
- Back-to-back commands with `io_resp_ready_i` tied 1 -> `io_cmd_yumi_o` pulses every 2nd cycle; 100 commands complete in 200 cycles, in order.
- With `els_p = 64`, 8-byte read of `0x400` after writing `0x0` with `64'hAA` -> with the macro, data all-ones and `0x0` is unaffected by a write to `0x400`; without it, data `64'hAA` (index wraps).
- Assert `reset_i` while in `e_resp` -> `io_resp_v_o` falls without waiting for a clock edge; the next command after deassertion is accepted normally.
